// File: rtl/commit_timing_probe.sv
// commit_timing_probe: passive timing probe placed beside the commit stage.
// Watches per-port commit valid/ack handshakes, measures valid-to-ack latency,
// counts commits and port-0 stall cycles, flags acks without valid, and (when
// COMMIT_PROBE_TRACE_EN is defined) logs timestamped commits into a trace FIFO.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              sync clear of stats, errors and trace (timestamp kept)
//   flush_i              zeroes in-flight latency trackers only
//   valid_i, ack_i       per-port commit handshake
//   trans_id_i           per-port transaction id, port 0 in the LSBs
//   commit_cnt_o         saturating count of accepted commits
//   stall_cnt_o          saturating count of valid&!ack cycles on port 0
//   max_lat_o            per-port max valid-to-ack latency, port 0 in the LSBs
//   proto_err_o          sticky: ack seen without valid
//   trace_rd_i           pop trace head
//   trace_valid_o        trace FIFO non-empty (first-word-fall-through)
//   trace_data_o         {timestamp, port, trans_id} of the head entry
//   trace_ovf_o          sticky: trace entry dropped because the FIFO was full
//
// Build option: COMMIT_PROBE_TRACE_EN enables the trace FIFO. Without it the
// trace outputs are tied to 0 and trace_rd_i is ignored.

// Per-port latency tracker: counts valid&!ack cycles, records the largest
// count observed at the accepting cycle.
module commit_lat_lane #(
  parameter int LAT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             ack_i,
  output logic [LAT_W-1:0] max_lat_o
);
  logic [LAT_W-1:0] lat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_q     <= '0;
      max_lat_o <= '0;
    end else begin
      // flush wins over the increment; otherwise any non-stall cycle restarts
      if (flush_i)               lat_q <= '0;
      else if (valid_i && !ack_i) lat_q <= (&lat_q) ? lat_q : lat_q + 1'b1;
      else                       lat_q <= '0;

      // the sample is the pre-accept count, so a same-cycle ack reads 0
      if (clear_i)                                  max_lat_o <= '0;
      else if (valid_i && ack_i && lat_q > max_lat_o) max_lat_o <= lat_q;
    end
  end
endmodule

module commit_timing_probe #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int TRANS_ID_BITS   = 3,
  parameter int CNT_W           = 32,
  parameter int LAT_W           = 8,
  parameter int TRACE_DEPTH     = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     clear_i,
  input  logic                                     flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]               valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]               ack_i,
  input  logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] trans_id_i,
  output logic [CNT_W-1:0]                         commit_cnt_o,
  output logic [CNT_W-1:0]                         stall_cnt_o,
  output logic [NR_COMMIT_PORTS*LAT_W-1:0]         max_lat_o,
  output logic                                     proto_err_o,
  input  logic                                     trace_rd_i,
  output logic                                     trace_valid_o,
  output logic [CNT_W+$clog2(NR_COMMIT_PORTS)+TRANS_ID_BITS-1:0] trace_data_o,
  output logic                                     trace_ovf_o
);
  localparam int PW = $clog2(NR_COMMIT_PORTS);
  localparam int TW = CNT_W + PW + TRANS_ID_BITS;
  localparam int NW = $clog2(NR_COMMIT_PORTS + 1);

  logic [NR_COMMIT_PORTS-1:0]            accept;
  logic [NR_COMMIT_PORTS-1:0][LAT_W-1:0] lane_max;
  logic [NW-1:0]                         n_acc;
  logic [CNT_W:0]                        commit_sum, stall_sum;
  logic [CNT_W-1:0]                      ts_q;

  assign accept    = valid_i & ack_i;
  assign max_lat_o = lane_max;

  for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_lane
    commit_lat_lane #(.LAT_W(LAT_W)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .flush_i  (flush_i),
      .valid_i  (valid_i[p]),
      .ack_i    (ack_i[p]),
      .max_lat_o(lane_max[p])
    );
  end

  always_comb begin
    n_acc = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) n_acc = n_acc + NW'(accept[p]);
  end

  // one extra bit catches the carry for saturation
  assign commit_sum = {1'b0, commit_cnt_o} + (CNT_W+1)'(n_acc);
  assign stall_sum  = {1'b0, stall_cnt_o} + (CNT_W+1)'(valid_i[0] & ~ack_i[0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_cnt_o <= '0;
      stall_cnt_o  <= '0;
      proto_err_o  <= 1'b0;
      ts_q         <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clear_i) begin
        commit_cnt_o <= '0;
        stall_cnt_o  <= '0;
        proto_err_o  <= 1'b0;
      end else begin
        commit_cnt_o <= commit_sum[CNT_W] ? '1 : commit_sum[CNT_W-1:0];
        stall_cnt_o  <= stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
        if (|(ack_i & ~valid_i)) proto_err_o <= 1'b1;
      end
    end
  end

`ifdef COMMIT_PROBE_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = $clog2(TRACE_DEPTH + 1);

  logic [TW-1:0]                      mem [TRACE_DEPTH];
  logic [AW-1:0]                      wr_ptr, rd_ptr;
  logic [CW-1:0]                      cnt_q;
  logic                               pop, drop;
  logic [CW:0]                        free, n_wr;
  logic [NR_COMMIT_PORTS-1:0]         we;
  logic [NR_COMMIT_PORTS-1:0][AW-1:0] slot;
  logic [NR_COMMIT_PORTS-1:0][TW-1:0] entry;

  // {timestamp, port, id} built arithmetically so a 1-port build (no port
  // field) needs no zero-width slice
  for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_entry
    assign entry[p] = (TW'(ts_q) << (PW + TRANS_ID_BITS)) |
                      (TW'(p) << TRANS_ID_BITS) |
                      TW'(trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]);
  end

  assign pop  = trace_rd_i & (cnt_q != '0);
  // a pop on a full FIFO frees its slot for this cycle's writes
  assign free = (CW+1)'(TRACE_DEPTH) - {1'b0, cnt_q} + (CW+1)'(pop);

  // pack accepts into consecutive slots, lowest port first; overflow drops
  // the highest ports
  always_comb begin
    n_wr = '0;
    drop = 1'b0;
    we   = '0;
    slot = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (accept[p]) begin
        if (n_wr < free) begin
          we[p]   = 1'b1;
          slot[p] = wr_ptr + AW'(n_wr);
          n_wr    = n_wr + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i)
      for (int p = 0; p < NR_COMMIT_PORTS; p++)
        if (we[p]) mem[slot[p]] <= entry[p];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      trace_ovf_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      trace_ovf_o <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_wr);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt_q  <= cnt_q + CW'(n_wr) - CW'(pop);
      if (drop) trace_ovf_o <= 1'b1;
    end
  end

  assign trace_valid_o = (cnt_q != '0);
  assign trace_data_o  = trace_valid_o ? mem[rd_ptr] : '0;
`else
  logic unused_trace;
  assign unused_trace  = ^{trace_rd_i, ts_q, trans_id_i};
  assign trace_valid_o = 1'b0;
  assign trace_data_o  = '0;
  assign trace_ovf_o   = 1'b0;
`endif
endmodule

// File: tb/tb_commit_timing_probe.sv
// Scoreboard bench for commit_timing_probe (default parameters). Stimulus
// steps a queue/array reference model each cycle and pushes the expected
// post-edge outputs; a monitor pops one expectation per clock and compares.
module tb_commit_timing_probe;
  localparam int NP = 2, TID = 3, CW = 32, LW = 8, DEPTH = 16, PW = 1;
  localparam int TW = CW + PW + TID;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 0, fl = 0, rd = 0;
  logic [NP-1:0] v = '0, a = '0;
  logic [NP*TID-1:0] ids = '0;
  logic [CW-1:0] commit_cnt, stall_cnt;
  logic [NP*LW-1:0] max_lat;
  logic perr, tvalid, tovf;
  logic [TW-1:0] tdata;

  commit_timing_probe dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .flush_i(fl),
    .valid_i(v), .ack_i(a), .trans_id_i(ids),
    .commit_cnt_o(commit_cnt), .stall_cnt_o(stall_cnt), .max_lat_o(max_lat),
    .proto_err_o(perr), .trace_rd_i(rd), .trace_valid_o(tvalid),
    .trace_data_o(tdata), .trace_ovf_o(tovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint commit, stall, maxl, tdata;
    bit perr, tvalid, tovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_cur;
  int checks = 0, errors = 0;

  // reference model state
  int lat[NP], mx[NP];
  longint m_commit, m_stall, m_ts;
  bit m_perr, m_ovf;
  longint tq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin lat[p] = 0; mx[p] = 0; end
    m_commit = 0; m_stall = 0; m_ts = 0; m_perr = 0; m_ovf = 0;
    tq.delete();
  endfunction

  task automatic step(input logic [NP-1:0] vv, input logic [NP-1:0] aa,
                      input logic [NP*TID-1:0] ii, input bit cc, input bit ff,
                      input bit rr);
    exp_t e;
    int n;
    v = vv; a = aa; ids = ii; clr = cc; fl = ff; rd = rr;
    if (cc) begin
      m_commit = 0; m_stall = 0; m_perr = 0; m_ovf = 0;
      for (int p = 0; p < NP; p++) mx[p] = 0;
      tq.delete();
    end else begin
      n = 0;
      for (int p = 0; p < NP; p++)
        if (vv[p] && aa[p]) begin
          n++;
          if (lat[p] > mx[p]) mx[p] = lat[p];
        end
      m_commit = (m_commit + n > MAXC) ? MAXC : m_commit + n;
      if (vv[0] && !aa[0]) m_stall = (m_stall == MAXC) ? MAXC : m_stall + 1;
      if ((aa & ~vv) != '0) m_perr = 1;
`ifdef COMMIT_PROBE_TRACE_EN
      if (rr && tq.size() > 0) void'(tq.pop_front());
      for (int p = 0; p < NP; p++)
        if (vv[p] && aa[p]) begin
          if (tq.size() < DEPTH)
            tq.push_back((m_ts << (PW + TID)) | (longint'(p) << TID) |
                         longint'(ii[p*TID +: TID]));
          else
            m_ovf = 1;
        end
`endif
    end
    for (int p = 0; p < NP; p++) begin
      if (ff) lat[p] = 0;
      else if (vv[p] && !aa[p]) lat[p] = (lat[p] < 255) ? lat[p] + 1 : 255;
      else lat[p] = 0;
    end
    m_ts = (m_ts + 1) & MAXC;
    e.commit = m_commit;
    e.stall  = m_stall;
    e.maxl   = longint'(mx[0]) | (longint'(mx[1]) << LW);
    e.perr   = m_perr;
`ifdef COMMIT_PROBE_TRACE_EN
    e.tvalid = (tq.size() > 0);
    e.tdata  = (tq.size() > 0) ? tq[0] : 0;
    e.tovf   = m_ovf;
`else
    e.tvalid = 0; e.tdata = 0; e.tovf = 0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, 0, 0, 0);
  endtask

  task automatic rand_step();
    logic [NP-1:0] vv, aa;
    for (int p = 0; p < NP; p++) begin
      vv[p] = ($urandom_range(0, 99) < 70);
      aa[p] = vv[p] ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 199) == 0);
    end
    step(vv, aa, NP*TID'($urandom), $urandom_range(0, 99) == 0,
         $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 0; v = '0; a = '0; ids = '0; clr = 0; fl = 0; rd = 0;
    sbq.delete();
    model_reset();
    #1;
    chk("rst_commit", commit_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_maxlat", max_lat, 0);
    chk("rst_perr", perr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tovf", tovf, 0);
    #1;
    rst_n = 1;
  endtask

  // monitor: the expectation pushed before a posedge describes the state
  // registered at that edge; compare on the following negedge
  initial begin
    forever begin
      @(posedge clk);
      if (sbq.size() > 0) begin
        mon_cur = sbq.pop_front();
        @(negedge clk);
        chk("commit_cnt", commit_cnt, mon_cur.commit);
        chk("stall_cnt", stall_cnt, mon_cur.stall);
        chk("max_lat", max_lat, mon_cur.maxl);
        chk("proto_err", perr, longint'(mon_cur.perr));
        chk("trace_valid", tvalid, longint'(mon_cur.tvalid));
        chk("trace_ovf", tovf, longint'(mon_cur.tovf));
        if (mon_cur.tvalid) chk("trace_data", tdata, mon_cur.tdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(10);

    // port 0 stalls three cycles then accepts
    repeat (3) step(2'b01, 2'b00, '0, 0, 0, 0);
    step(2'b01, 2'b01, '0, 0, 0, 0);
    chk("lat3_max", max_lat[LW-1:0], 3);
    chk("lat3_stall", stall_cnt, 3);
    chk("lat3_commit", commit_cnt, 1);
    idle(1);

    // ack without valid on port 1, then clear
    step(2'b00, 2'b10, '0, 0, 0, 0);
    chk("perr_set", perr, 1);
    step('0, '0, '0, 1, 0, 0);
    chk("clr_perr", perr, 0);
    chk("clr_commit", commit_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    chk("clr_maxlat", max_lat, 0);

    // long stall saturates the latency sample
    repeat (300) step(2'b01, 2'b00, '0, 0, 0, 0);
    step(2'b01, 2'b01, '0, 0, 0, 0);
    chk("sat_max", max_lat[LW-1:0], 255);
    chk("sat_stall", stall_cnt, 300);
    idle(1);

    // flush restarts an in-flight measurement
    step('0, '0, '0, 1, 0, 0);
    repeat (5) step(2'b01, 2'b00, '0, 0, 0, 0);
    step(2'b01, 2'b00, '0, 0, 1, 0);
    repeat (2) step(2'b01, 2'b00, '0, 0, 0, 0);
    step(2'b01, 2'b01, '0, 0, 0, 0);
    chk("flush_max", max_lat[LW-1:0], 2);

    // fill the trace, then two accepts with a pop on full
    step('0, '0, '0, 1, 0, 0);
    repeat (8) step(2'b11, 2'b11, NP*TID'($urandom), 0, 0, 0);
    step(2'b11, 2'b11, NP*TID'($urandom), 0, 0, 1);
`ifdef COMMIT_PROBE_TRACE_EN
    chk("full_ovf", tovf, 1);
    chk("full_valid", tvalid, 1);
`else
    chk("full_ovf", tovf, 0);
    chk("full_valid", tvalid, 0);
`endif
    repeat (20) step('0, '0, '0, 0, 0, 1);

    repeat (3000) rand_step();

    // reset in the middle of traffic, then the timestamp-tagged pair
    do_reset();
    idle(7);
    step(2'b11, 2'b11, {3'd2, 3'd5}, 0, 0, 0);
`ifdef COMMIT_PROBE_TRACE_EN
    chk("trace_head0", tdata, 64'h75);
`else
    chk("trace_head0", tdata, 0);
`endif
    step('0, '0, '0, 0, 0, 1);
`ifdef COMMIT_PROBE_TRACE_EN
    chk("trace_head1", tdata, 64'h7A);
`else
    chk("trace_head1", tdata, 0);
`endif
    step('0, '0, '0, 0, 0, 1);
    chk("trace_drained", tvalid, 0);

    repeat (500) rand_step();
    idle(1);
    @(negedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
